// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and ALUCtr opcodes. The CPU control
// decoder imports this package too, so the two always agree on the encodings.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int CTR_W = 4;

  localparam logic [CTR_W-1:0] ALU_ADDU  = 4'd0;
  localparam logic [CTR_W-1:0] ALU_SUBU  = 4'd1;
  localparam logic [CTR_W-1:0] ALU_AND   = 4'd2;
  localparam logic [CTR_W-1:0] ALU_OR    = 4'd3;
  localparam logic [CTR_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [CTR_W-1:0] ALU_NOR   = 4'd5;
  localparam logic [CTR_W-1:0] ALU_SLT   = 4'd6;
  localparam logic [CTR_W-1:0] ALU_SLTU  = 4'd7;
  localparam logic [CTR_W-1:0] ALU_SLL   = 4'd8;
  localparam logic [CTR_W-1:0] ALU_SRL   = 4'd9;
  localparam logic [CTR_W-1:0] ALU_SRA   = 4'd10;
  localparam logic [CTR_W-1:0] ALU_LUI   = 4'd11;
  localparam logic [CTR_W-1:0] ALU_ADD   = 4'd12;
  localparam logic [CTR_W-1:0] ALU_SUB   = 4'd13;
  localparam logic [CTR_W-1:0] ALU_PASSA = 4'd14;
  localparam logic [CTR_W-1:0] ALU_PASSB = 4'd15;

  // Operations that drive the shared adder in subtract mode.
  function automatic logic is_subtract(input logic [CTR_W-1:0] op);
    return (op == ALU_SUBU) || (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and its user. The master drives the
// operands and opcode; the ALU (slave) returns the registered result and flags.
interface alu_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [CTR_W-1:0] ALUCtr;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;

  modport master (output A, B, ALUCtr, input Result, Zero, Overflow);
  modport slave  (input A, B, ALUCtr, output Result, Zero, Overflow);

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder/subtractor feeds the arithmetic
// and compare ops; shifts take their amount from a[4:0].
module alu_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CTR_W-1:0] op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             ovf_raw;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [4:0]       shamt;

  assign sub   = is_subtract(op);
  assign b_x   = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
  assign shamt = a[4:0];

  // With b already inverted for subtraction, one rule covers both directions:
  // like-signed effective operands producing a sum of the opposite sign.
  assign ovf_raw     = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign lt_signed   = sum[WIDTH-1] ^ ovf_raw;
  assign lt_unsigned = ~sum[WIDTH];

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path through it can leave a value held and infer a latch.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADDU, ALU_SUBU: result = sum[WIDTH-1:0];
      ALU_ADD, ALU_SUB: begin
        result   = sum[WIDTH-1:0];
        overflow = ovf_raw;
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_SLL:   result = b << shamt;
      ALU_SRL:   result = b >> shamt;
      ALU_SRA:   result = WIDTH'($signed(b) >>> shamt);
      ALU_LUI:   result = {b[15:0], 16'h0000};
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: wraps alu_core and captures result, zero and overflow one
// cycle after the operands are sampled. Synchronous active-high reset.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] core_result;
  logic             core_overflow;

  alu_core u_core (
    .a        (bus.A),
    .b        (bus.B),
    .op       (bus.ALUCtr),
    .result   (core_result),
    .overflow (core_overflow)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Result   <= '0;
      bus.Zero     <= 1'b1;
      bus.Overflow <= 1'b0;
    end else begin
      bus.Result   <= core_result;
      bus.Zero     <= (core_result == '0);
      bus.Overflow <= core_overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU; expected values are
// hand-computed constants.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  // Drive operands, then step one edge and settle so outputs can be sampled.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUCtr = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(ALU_PASSA, 32'hFFFF_FFFF, 32'h1);
    apply(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    n_cmp++;
    if (bus.Result !== 32'h0 || bus.Zero !== 1'b1 || bus.Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got R=%h Z=%b V=%b want R=00000000 Z=1 V=0",
               bus.Result, bus.Zero, bus.Overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_shift();
    vec_t v [4];
    v[0] = '{ALU_SLL, 32'h0000_0011, 32'h0000_007B, 32'h00F6_0000, 1'b0};
    v[1] = '{ALU_SRA, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 1'b0};
    v[2] = '{ALU_SRL, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000, 1'b0};
    v[3] = '{ALU_SRA, 32'hFFFF_FFE0, 32'h8765_4321, 32'h8765_4321, 1'b0};
    foreach (v[i]) begin
      apply(v[i].op, v[i].a, v[i].b);
      n_cmp++;
      if (bus.Result !== v[i].r || bus.Zero !== 1'b0 || bus.Overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL shift[%0d]: got R=%h Z=%b V=%b want R=%h Z=0 V=0",
                 i, bus.Result, bus.Zero, bus.Overflow, v[i].r);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v [4];
    v[0] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1};
    v[1] = '{ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0};
    v[2] = '{ALU_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1};
    v[3] = '{ALU_SUBU, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0};
    foreach (v[i]) begin
      apply(v[i].op, v[i].a, v[i].b);
      n_cmp++;
      if (bus.Result !== v[i].r || bus.Overflow !== v[i].ov) begin
        n_bad++;
        $display("FAIL overflow[%0d]: got R=%h V=%b want R=%h V=%b",
                 i, bus.Result, bus.Overflow, v[i].r, v[i].ov);
      end
    end
  endtask

  task automatic test_compare();
    apply(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (bus.Result !== 32'h1) begin
      n_bad++;
      $display("FAIL slt: got %h want 00000001", bus.Result);
    end
    apply(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (bus.Result !== 32'h0 || bus.Zero !== 1'b1) begin
      n_bad++;
      $display("FAIL sltu: got R=%h Z=%b want R=00000000 Z=1", bus.Result, bus.Zero);
    end
    apply(ALU_SLTU, 32'h1, 32'hFFFF_FFFF);
    n_cmp++;
    if (bus.Result !== 32'h1) begin
      n_bad++;
      $display("FAIL sltu_rev: got %h want 00000001", bus.Result);
    end
  endtask

  task automatic test_zero_and_midstream_reset();
    apply(ALU_SUBU, 32'h5, 32'h5);
    n_cmp++;
    if (bus.Result !== 32'h0 || bus.Zero !== 1'b1) begin
      n_bad++;
      $display("FAIL zero: got R=%h Z=%b want R=00000000 Z=1", bus.Result, bus.Zero);
    end
    apply(ALU_ADDU, 32'h1, 32'h2);
    n_cmp++;
    if (bus.Result !== 32'h3 || bus.Zero !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset: got R=%h Z=%b want R=00000003 Z=0", bus.Result, bus.Zero);
    end
    reset = 1'b1;
    apply(ALU_ADDU, 32'h1, 32'h2);
    n_cmp++;
    if (bus.Result !== 32'h0 || bus.Zero !== 1'b1 || bus.Overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got R=%h Z=%b V=%b want R=00000000 Z=1 V=0",
               bus.Result, bus.Zero, bus.Overflow);
    end
    reset = 1'b0;
    apply(ALU_ADD, 32'h7, 32'h8);
    n_cmp++;
    if (bus.Result !== 32'hF || bus.Zero !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: got R=%h Z=%b want R=0000000f Z=0", bus.Result, bus.Zero);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [12];
    v[0]  = '{ALU_ADDU,  32'h1,         32'h2,         32'h3,         1'b0};
    v[1]  = '{ALU_SUBU,  32'h10,        32'h3,         32'hD,         1'b0};
    v[2]  = '{ALU_AND,   32'hF0,        32'h3C,        32'h30,        1'b0};
    v[3]  = '{ALU_OR,    32'hF0,        32'h0F,        32'hFF,        1'b0};
    v[4]  = '{ALU_XOR,   32'hFF,        32'h0F,        32'hF0,        1'b0};
    v[5]  = '{ALU_NOR,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
    v[6]  = '{ALU_LUI,   32'h0,         32'hABCD_1234, 32'h1234_0000, 1'b0};
    v[7]  = '{ALU_PASSA, 32'hDEAD_BEEF, 32'h1,         32'hDEAD_BEEF, 1'b0};
    v[8]  = '{ALU_PASSB, 32'h1,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    v[9]  = '{ALU_SLL,   32'h0,         32'h55,        32'h55,        1'b0};
    v[10] = '{ALU_SLL,   32'hFFFF_FFE1, 32'h1,         32'h2,         1'b0};
    v[11] = '{ALU_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
    foreach (v[i]) begin
      apply(v[i].op, v[i].a, v[i].b);
      n_cmp++;
      if (bus.Result !== v[i].r || bus.Zero !== (v[i].r == 32'h0) ||
          bus.Overflow !== v[i].ov) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got R=%h Z=%b V=%b want R=%h Z=%b V=%b",
                 i, bus.Result, bus.Zero, bus.Overflow, v[i].r, v[i].r == 32'h0, v[i].ov);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.A      = '0;
    bus.B      = '0;
    bus.ALUCtr = '0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_overflow();
    test_compare();
    test_zero_and_midstream_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
